// File: rtl/hood_pkg.sv
// Shared definitions for the kitchen-hood fan sequencer.
//   - mode_state encodings presented to the fan datapath
//   - FSM state enum
//   - 6-bit minute/second time type, MAX_SEC constant
//   - helpers that split a duration in seconds into min/sec fields
package hood_pkg;

    localparam logic [2:0] MODE_STBY = 3'd0;
    localparam logic [2:0] MODE_G1   = 3'd1;
    localparam logic [2:0] MODE_G2   = 3'd2;
    localparam logic [2:0] MODE_HUR  = 3'd3;

    typedef enum logic [2:0] {
        StStby,
        StG1,
        StG2,
        StHur,
        StExit
    } fsm_state_e;

    typedef logic [5:0] time6_t;

    localparam time6_t MAX_SEC = 6'd59;

    // Minutes field of a duration; clamped so the field never exceeds 59.
    function automatic time6_t secs_to_min(input int unsigned secs);
        int unsigned m;
        m = secs / 60;
        if (m > 59) begin
            m = 59;
        end
        return time6_t'(m);
    endfunction

    function automatic time6_t secs_to_sec(input int unsigned secs);
        return time6_t'(secs % 60);
    endfunction

endpackage

// File: rtl/hood_fan_sequencer_mm_ss_counter.sv
// mm_ss_counter: minute/second counter, binary fields 0..59.
//   COUNT_DOWN = 1 : counts down on tick, holds at 00:00 (never underflows)
//   COUNT_DOWN = 0 : counts up on tick, 59:59 wraps to 00:00
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset (clears to 00:00)
//   i_load                 load i_load_min/i_load_sec; takes priority over i_tick
//   i_load_min, i_load_sec value to load
//   i_tick                 count enable
//   o_min, o_sec           current value
//   o_zero                 value is 00:00
module mm_ss_counter
    import hood_pkg::*;
#(
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [5:0] i_load_min,
    input  logic [5:0] i_load_sec,
    input  logic       i_tick,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic       o_zero
);

    time6_t r_min;
    time6_t r_sec;
    time6_t w_min_next;
    time6_t w_sec_next;

    always_comb begin
        w_min_next = r_min;
        w_sec_next = r_sec;
        if (i_load) begin
            w_min_next = i_load_min;
            w_sec_next = i_load_sec;
        end else if (i_tick) begin
            if (COUNT_DOWN) begin
                if (r_sec != 6'd0) begin
                    w_sec_next = r_sec - 6'd1;
                end else if (r_min != 6'd0) begin
                    w_min_next = r_min - 6'd1;
                    w_sec_next = MAX_SEC;
                end
            end else begin
                if (r_sec != MAX_SEC) begin
                    w_sec_next = r_sec + 6'd1;
                end else begin
                    w_sec_next = 6'd0;
                    w_min_next = (r_min == MAX_SEC) ? 6'd0 : r_min + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_min <= 6'd0;
            r_sec <= 6'd0;
        end else begin
            r_min <= w_min_next;
            r_sec <= w_sec_next;
        end
    end

    assign o_min  = r_min;
    assign o_sec  = r_sec;
    assign o_zero = (r_min == 6'd0) && (r_sec == 6'd0);

endmodule

// File: rtl/hood_fan_sequencer.sv
// hood_fan_sequencer: fan-mode controller for the kitchen hood.
// Turns debounced button pulses into the fan gear and drives the time display.
// States: standby, gear1, gear2, one-shot hurricane, timed exit (fan at gear2) back to standby.
// All timing is derived from the 1 Hz tick enable.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   tick_1hz                  one-cycle pulse per second
//   menu_btn                  return toward standby (highest priority)
//   mode1_btn..mode3_btn      request gear1 / gear2 / hurricane (mode3 > mode2 > mode1)
//   mode_state[2:0]           0=standby 1=gear1 2=gear2 3=hurricane
//   cd_min, cd_sec            countdown remaining, zero outside hurricane/exit
//   run_min, run_sec          cumulative fan-on time, wraps at 59:59
//   display_select            1 = show countdown, 0 = show run time
//   hurricane_used            hurricane already consumed
// Configuration macro: HURRICANE_REARM_EN -- when defined, REARM_SEC seconds of continuous
// standby re-arm the hurricane; otherwise hurricane_used clears only on reset.
module hood_fan_sequencer
    import hood_pkg::*;
#(
    parameter int unsigned HURRICANE_SEC = 60,
    parameter int unsigned EXIT_SEC      = 60,
    parameter int unsigned REARM_SEC     = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       menu_btn,
    input  logic       mode1_btn,
    input  logic       mode2_btn,
    input  logic       mode3_btn,
    output logic [2:0] mode_state,
    output logic [5:0] cd_min,
    output logic [5:0] cd_sec,
    output logic [5:0] run_min,
    output logic [5:0] run_sec,
    output logic       display_select,
    output logic       hurricane_used
);

    localparam time6_t HurMin  = secs_to_min(HURRICANE_SEC);
    localparam time6_t HurSec  = secs_to_sec(HURRICANE_SEC);
    localparam time6_t ExitMin = secs_to_min(EXIT_SEC);
    localparam time6_t ExitSec = secs_to_sec(EXIT_SEC);

    fsm_state_e r_state;
    fsm_state_e w_state_next;
    logic       r_used;

    logic       w_cd_load;
    time6_t     w_cd_load_min;
    time6_t     w_cd_load_sec;
    logic       w_cd_tick;
    time6_t     w_cd_min;
    time6_t     w_cd_sec;
    logic       w_cd_zero;
    logic       w_cd_last;
    logic       w_take_hur;
    logic       w_rearm;
    logic       w_run_tick;
    logic       w_show_cd;

    // Countdown sits at 00:01: the next tick empties it.
    assign w_cd_last = (w_cd_min == 6'd0) && (w_cd_sec == 6'd1);

    always_comb begin
        w_state_next  = r_state;
        w_cd_load     = 1'b0;
        w_cd_load_min = 6'd0;
        w_cd_load_sec = 6'd0;
        w_cd_tick     = 1'b0;
        w_take_hur    = 1'b0;
        unique case (r_state)
            StStby, StG1, StG2: begin
                // Only the highest-priority pressed button is considered; if it has
                // no effect (e.g. mode3 with hurricane used) the cycle is a no-op.
                if (menu_btn) begin
                    w_state_next = StStby;
                end else if (mode3_btn) begin
                    if (!r_used) begin
                        w_state_next  = StHur;
                        w_cd_load     = 1'b1;
                        w_cd_load_min = HurMin;
                        w_cd_load_sec = HurSec;
                        w_take_hur    = 1'b1;
                    end
                end else if (mode2_btn) begin
                    w_state_next = StG2;
                end else if (mode1_btn) begin
                    w_state_next = StG1;
                end
            end
            StHur: begin
                if (menu_btn) begin
                    // Reload wins over a coincident tick.
                    w_state_next  = StExit;
                    w_cd_load     = 1'b1;
                    w_cd_load_min = ExitMin;
                    w_cd_load_sec = ExitSec;
                end else if (w_cd_zero) begin
                    w_state_next = StG2;
                end else if (tick_1hz) begin
                    w_cd_tick = 1'b1;
                    if (w_cd_last) begin
                        w_state_next = StG2;
                    end
                end
            end
            StExit: begin
                if (w_cd_zero) begin
                    w_state_next = StStby;
                end else if (tick_1hz) begin
                    w_cd_tick = 1'b1;
                    if (w_cd_last) begin
                        w_state_next = StStby;
                    end
                end
            end
            default: begin
                w_state_next = StStby;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StStby;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used <= 1'b0;
        end else if (w_take_hur) begin
            r_used <= 1'b1;
        end else if (w_rearm) begin
            r_used <= 1'b0;
        end
    end

`ifdef HURRICANE_REARM_EN
    localparam int unsigned SbyW = $clog2(REARM_SEC + 1);
    localparam logic [SbyW-1:0] RearmMax  = SbyW'(REARM_SEC);
    localparam logic [SbyW-1:0] RearmLast = SbyW'(REARM_SEC - 1);

    logic [SbyW-1:0] r_sby_cnt;
    logic            w_stay_sby;

    assign w_stay_sby = (r_state == StStby) && (w_state_next == StStby);

    // Saturates at REARM_SEC so the clear fires once per standby stretch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sby_cnt <= '0;
        end else if (!w_stay_sby) begin
            r_sby_cnt <= '0;
        end else if (tick_1hz && (r_sby_cnt != RearmMax)) begin
            r_sby_cnt <= r_sby_cnt + 1'b1;
        end
    end

    assign w_rearm = w_stay_sby && tick_1hz && (r_sby_cnt == RearmLast);
`else
    logic w_unused_rearm;
    assign w_unused_rearm = ^REARM_SEC;
    assign w_rearm        = 1'b0;
`endif

    mm_ss_counter #(
        .COUNT_DOWN (1'b1)
    ) u_countdown (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_cd_load),
        .i_load_min (w_cd_load_min),
        .i_load_sec (w_cd_load_sec),
        .i_tick     (w_cd_tick),
        .o_min      (w_cd_min),
        .o_sec      (w_cd_sec),
        .o_zero     (w_cd_zero)
    );

    // Run time accumulates whenever the fan is on (any state but standby).
    assign w_run_tick = tick_1hz && (r_state != StStby);

    logic w_run_zero_unused;

    mm_ss_counter #(
        .COUNT_DOWN (1'b0)
    ) u_run_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (1'b0),
        .i_load_min (6'd0),
        .i_load_sec (6'd0),
        .i_tick     (w_run_tick),
        .o_min      (run_min),
        .o_sec      (run_sec),
        .o_zero     (w_run_zero_unused)
    );

    always_comb begin
        mode_state = MODE_STBY;
        unique case (r_state)
            StG1:         mode_state = MODE_G1;
            StG2, StExit: mode_state = MODE_G2;
            StHur:        mode_state = MODE_HUR;
            default:      mode_state = MODE_STBY;
        endcase
    end

    assign w_show_cd      = (r_state == StHur) || (r_state == StExit);
    assign display_select = w_show_cd;
    assign cd_min         = w_show_cd ? w_cd_min : 6'd0;
    assign cd_sec         = w_show_cd ? w_cd_sec : 6'd0;
    assign hurricane_used = r_used;

endmodule
